uart_rx_fsm: RTL
================

Name: uart_rx_fsm

Overview:
- Control stage of the UART receiver. It detects the start bit and runs the edge and bit counters.
- It sequences the neighbouring RX stages through one-cycle enables: data sampler, deserializer, start/parity/stop checkers. It sits directly upstream of the parity checker and drives its par_chk_en.
- It consumes the checker error flags and issues data_valid or an error indication per frame.

Parameters:
- BUS_WIDTH, 8, data bits per frame (LSB first).
- PRESCALE_WIDTH, 6, width of Prescale and edge_cnt. Legal Prescale values are 8, 16, 32.
- BIT_CNT_WIDTH, 4, width of bit_cnt. Must hold BUS_WIDTH+2.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  1 = frame carries a parity bit.
- Prescale  in  PRESCALE_WIDTH  clocks per bit.
- strt_glitch  in  1  start checker result, registered.
- par_err  in  1  parity checker result, registered.
- stp_err  in  1  stop checker result, registered.
- edge_cnt  out  PRESCALE_WIDTH  clock index within the current bit.
- bit_cnt  out  BIT_CNT_WIDTH  bit index: 0 = start, 1..BUS_WIDTH = data, then parity, then stop.
- dat_samp_en  out  1  sampler enable.
- strt_chk_en  out  1  start check pulse.
- deser_en  out  1  deserializer shift pulse.
- par_chk_en  out  1  parity check pulse.
- stp_chk_en  out  1  stop check pulse.
- data_valid  out  1  one-cycle pulse: frame received clean.
- frame_err  out  1  one-cycle pulse: stop bit error.
- parity_err  out  1  one-cycle pulse: parity error.

Behaviour:
- Reset (RST low, any time, including mid-frame): state IDLE; counters 0; all outputs 0; latched PAR_EN and Prescale cleared; sticky error flag cleared.
- Constants:
  - CHK = Prescale/2+2. This is the first cycle the sampled bit is valid; the sampler majority-votes at Prescale/2-1, Prescale/2 and Prescale/2+1.
  - CAP = CHK+1, the cycle a registered checker result is read. CAP ≤ Prescale-1 for all legal Prescale values.
- Counters: edge_cnt increments every cycle outside IDLE. At Prescale-1 it wraps to 0 and bit_cnt increments. Both are held at 0 in IDLE.
- dat_samp_en: 1 in every non-IDLE state.
- Enables: every *_chk_en and deser_en is high for exactly one cycle, at edge_cnt == CHK of the relevant bit, and 0 otherwise.
- State IDLE:
  - The cycle RX_IN == 0 is seen counts as edge 0 of the start bit.
  - In that cycle, latch PAR_EN and Prescale, then go to START with edge_cnt = 1.
  - PAR_EN and Prescale changes mid-frame are ignored.
- State START:
  - strt_chk_en pulses at CHK.
  - At CAP, if strt_glitch == 1, return to IDLE at once and clear the counters. No output pulse.
  - Otherwise, at the bit end go to DATA.
- State DATA:
  - deser_en pulses at CHK of each of the BUS_WIDTH data bits.
  - After the last data bit, go to PARITY if latched PAR_EN == 1, else to STOP.
- State PARITY:
  - par_chk_en pulses at CHK.
  - At CAP, capture par_err into the sticky flag.
  - At the bit end go to STOP.
- State STOP:
  - stp_chk_en pulses at CHK.
  - At CAP, evaluate and go to IDLE; do not wait for the remaining stop-bit clocks.
  - In the next cycle exactly one of these pulses for one cycle:
    - data_valid, when no errors;
    - frame_err, when stp_err == 1;
    - parity_err, when only par_err is set.
  - When both errors occur, frame_err and parity_err pulse together.
- Back-to-back frames: a low RX_IN in the IDLE cycle that carries the output pulse starts a new frame, with no dead cycle.
- RX_IN high throughout the start bit is handled by the start checker via strt_glitch; the FSM adds no extra filtering.

Test Plan:
- Reset then RX_IN held high 50 cycles -> state IDLE; edge_cnt = bit_cnt = 0; all enables and pulses 0.
- Prescale = 8, PAR_EN = 1, frame 0xA5 with correct parity, start detected at T0:
  - strt_chk_en at T6;
  - deser_en at T14, T22, …, T70;
  - par_chk_en at T78;
  - stp_chk_en at T86;
  - data_valid high only at T88.
- Same frame with PAR_EN = 0 -> no par_chk_en; stp_chk_en at T78; data_valid at T80; bit_cnt reaches 9 in STOP.
- Prescale = 16, PAR_EN = 1, wrong parity (par_err = 1 at T0+154) -> parity_err pulse at T0+172; data_valid stays 0.
- Prescale = 8, strt_glitch = 1 at T7 -> IDLE at T8; no deser_en; no output pulse.
- Separate runs:
  - RST low at T40 mid-DATA -> all outputs 0 in the same cycle (asynchronous); after release, a new start is detected normally.
  - Two frames back-to-back -> second data_valid exactly 88 cycles after the first (Prescale = 8, parity on).

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART RX sequencer and its neighbouring
// sampler, deserializer and checker stages.
interface uart_rx_fsm_if #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      strt_glitch;
  logic                      par_err;
  logic                      stp_err;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      dat_samp_en;
  logic                      strt_chk_en;
  logic                      deser_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      data_valid;
  logic                      frame_err;
  logic                      parity_err;

  modport master (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );

  modport slave (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver control stage: start detection, edge/bit counting, one-cycle
// enables for the RX datapath stages and per-frame result pulses.
module uart_rx_fsm #(
  parameter int BUS_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_fsm_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_q, bit_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      pen_q, pen_d;
  logic                      sticky_q, sticky_d;
  logic                      dv_q, dv_d;
  logic                      fe_q, fe_d;
  logic                      pe_q, pe_d;

  logic [PRESCALE_WIDTH-1:0] chk;
  logic                      at_chk, at_cap, last_edge;

  always_comb begin
    chk       = (pre_q >> 1) + PRESCALE_WIDTH'(2);
    at_chk    = (edge_q == chk);
    at_cap    = (edge_q == chk + PRESCALE_WIDTH'(1));
    last_edge = (edge_q == pre_q - PRESCALE_WIDTH'(1));
  end

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    pre_d    = pre_q;
    pen_d    = pen_q;
    sticky_d = sticky_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;

    if (state_q != IDLE) begin
      if (last_edge) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_CNT_WIDTH'(1);
      end else begin
        edge_d = edge_q + PRESCALE_WIDTH'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        // The detection cycle itself is edge 0 of the start bit.
        if (!bus.RX_IN) begin
          pen_d    = bus.PAR_EN;
          pre_d    = bus.Prescale;
          sticky_d = 1'b0;
          edge_d   = PRESCALE_WIDTH'(1);
          state_d  = START;
        end
      end
      START: begin
        if (at_cap && bus.strt_glitch) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (last_edge) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_edge && bit_q == BIT_CNT_WIDTH'(BUS_WIDTH)) begin
          state_d = pen_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_cap) sticky_d = bus.par_err;
        if (last_edge) state_d = STOP;
      end
      STOP: begin
        // Verdict is taken at CAP; the tail of the stop bit is spent in IDLE.
        if (at_cap) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
          dv_d    = !bus.stp_err && !sticky_q;
          fe_d    = bus.stp_err;
          pe_d    = sticky_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      bit_q    <= '0;
      pre_q    <= '0;
      pen_q    <= 1'b0;
      sticky_q <= 1'b0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      pre_q    <= pre_d;
      pen_q    <= pen_d;
      sticky_q <= sticky_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
    end
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.dat_samp_en = (state_q != IDLE);
  assign bus.strt_chk_en = (state_q == START)  && at_chk;
  assign bus.deser_en    = (state_q == DATA)   && at_chk;
  assign bus.par_chk_en  = (state_q == PARITY) && at_chk;
  assign bus.stp_chk_en  = (state_q == STOP)   && at_chk;
  assign bus.data_valid  = dv_q;
  assign bus.frame_err   = fe_q;
  assign bus.parity_err  = pe_q;

endmodule
